mips_multicycle_control: RTL and testbench

- Control unit of the multicycle MIPS-32 subset CPU.
- Takes the opcode and funct fields of the latched instruction from the datapath.
- Sequences each instruction through a Moore FSM (fetch, decode, execute, memory, writeback).
- Drives every datapath mux select, write enable and ALU operation code; the datapath forms the PC enable as PCWrite | (Branch & zero).

---
 rtl/mips_multicycle_control.sv | 155 +++++++++++++++
 tb/tb_mips_multicycle_control.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS-32 subset control unit.
// Moore FSM: outputs decode from the current state only, except AluOP in EXECUTE,
// which follows Func. Reset forces FETCH-valued outputs with every write enable low.
module mips_multicycle_control (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [5:0] OP,
  input  logic [5:0] Func,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       PCSrc,
  output logic       Branch,
  output logic       PCWrite,
  output logic [2:0] AluOP,
  output logic       jump
);

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluSlt = 3'b111;

  typedef enum logic [3:0] {
    StFetch, StDecode, StMemAdr, StMemRd, StMemWb, StMemWr,
    StExecute, StAluWb, StBeqEx, StAddiEx, StAddiWb, StJex
  } state_t;

  state_t state_q;
  state_t state_out;

  // State register and next-state decode; OP is consulted only in DECODE and MEMADR.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= StFetch;
    end else begin
      unique case (state_q)
        StFetch:  state_q <= StDecode;
        StDecode: begin
          case (OP)
            OpLw, OpSw: state_q <= StMemAdr;
            OpRtype:    state_q <= StExecute;
            OpBeq:      state_q <= StBeqEx;
            OpAddi:     state_q <= StAddiEx;
            OpJ:        state_q <= StJex;
            default:    state_q <= StFetch;  // unsupported opcode acts as a no-op
          endcase
        end
        StMemAdr:  state_q <= (OP == OpSw) ? StMemWr : StMemRd;
        StMemRd:   state_q <= StMemWb;
        StMemWb:   state_q <= StFetch;
        StMemWr:   state_q <= StFetch;
        StExecute: state_q <= StAluWb;
        StAluWb:   state_q <= StFetch;
        StBeqEx:   state_q <= StFetch;
        StAddiEx:  state_q <= StAddiWb;
        StAddiWb:  state_q <= StFetch;
        StJex:     state_q <= StFetch;
        default:   state_q <= StFetch;
      endcase
    end
  end

  // While Reset is high the outputs show FETCH values regardless of the stored state.
  assign state_out = Reset ? StFetch : state_q;

  // Output decode from the state, with write enables masked during reset.
  always_comb begin
    IorD     = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    PCSrc    = 1'b0;
    Branch   = 1'b0;
    PCWrite  = 1'b0;
    AluOP    = AluAdd;
    jump     = 1'b0;
    unique case (state_out)
      StFetch: begin
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        ALUSrcB = 2'b01;
      end
      StDecode: ALUSrcB = 2'b11;  // branch target precomputed into ALUOut
      StMemAdr: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      StMemRd: IorD = 1'b1;
      StMemWb: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      StMemWr: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      StExecute: begin
        ALUSrcA = 1'b1;
        case (Func)
          6'b100010: AluOP = AluSub;
          6'b100100: AluOP = AluAnd;
          6'b100101: AluOP = AluOr;
          6'b101010: AluOP = AluSlt;
          default:   AluOP = AluAdd;
        endcase
      end
      StAluWb: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      StBeqEx: begin
        ALUSrcA = 1'b1;
        AluOP   = AluSub;
        PCSrc   = 1'b1;
        Branch  = 1'b1;
      end
      StAddiEx: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      StAddiWb: RegWrite = 1'b1;
      StJex: begin
        jump    = 1'b1;
        PCWrite = 1'b1;
      end
      default: ;
    endcase
    if (Reset) begin
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      PCWrite  = 1'b0;
      Branch   = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for the multicycle MIPS control unit: steps each instruction class
// through its states and compares the packed control word to hand-built expectations.
module tb_mips_multicycle_control;

  logic       CLK = 1'b0;
  logic       Reset;
  logic [5:0] OP;
  logic [5:0] Func;
  logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       PCSrc, Branch, PCWrite, jump;
  logic [2:0] AluOP;

  int checks = 0;
  int errors = 0;

  mips_multicycle_control dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .OP       (OP),
    .Func     (Func),
    .IorD     (IorD),
    .MemWrite (MemWrite),
    .IRWrite  (IRWrite),
    .RegDst   (RegDst),
    .MemtoReg (MemtoReg),
    .RegWrite (RegWrite),
    .ALUSrcA  (ALUSrcA),
    .ALUSrcB  (ALUSrcB),
    .PCSrc    (PCSrc),
    .Branch   (Branch),
    .PCWrite  (PCWrite),
    .AluOP    (AluOP),
    .jump     (jump)
  );

  always #5 CLK = ~CLK;

  // Packed order: IorD MemWrite IRWrite RegDst MemtoReg RegWrite ALUSrcA ALUSrcB[1:0]
  //               PCSrc Branch PCWrite AluOP[2:0] jump
  logic [15:0] ctrl;
  assign ctrl = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB,
                 PCSrc, Branch, PCWrite, AluOP, jump};

  // Expected control words, written field by field.
  localparam logic [15:0] EFetch  = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01,
                                     1'b0, 1'b0, 1'b1, 3'b010, 1'b0};
  localparam logic [15:0] ERstFet = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01,
                                     1'b0, 1'b0, 1'b0, 3'b010, 1'b0};
  localparam logic [15:0] EDecode = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11,
                                     1'b0, 1'b0, 1'b0, 3'b010, 1'b0};
  localparam logic [15:0] EMemAdr = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10,
                                     1'b0, 1'b0, 1'b0, 3'b010, 1'b0};
  localparam logic [15:0] EMemRd  = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00,
                                     1'b0, 1'b0, 1'b0, 3'b010, 1'b0};
  localparam logic [15:0] EMemWb  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00,
                                     1'b0, 1'b0, 1'b0, 3'b010, 1'b0};
  localparam logic [15:0] EMemWr  = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00,
                                     1'b0, 1'b0, 1'b0, 3'b010, 1'b0};
  localparam logic [15:0] EAluWb  = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00,
                                     1'b0, 1'b0, 1'b0, 3'b010, 1'b0};
  localparam logic [15:0] EBeqEx  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00,
                                     1'b1, 1'b1, 1'b0, 3'b110, 1'b0};
  localparam logic [15:0] EAddiWb = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00,
                                     1'b0, 1'b0, 1'b0, 3'b010, 1'b0};
  localparam logic [15:0] EJex    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00,
                                     1'b0, 1'b0, 1'b1, 3'b010, 1'b1};

  function automatic logic [15:0] e_exec(input logic [2:0] alu);
    return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, alu, 1'b0};
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  // Drives one instruction and checks n consecutive cycles starting at its FETCH.
  task automatic run(input string tag, input logic [5:0] op, input logic [5:0] fn,
                     input int n, input logic [15:0] s0, input logic [15:0] s1,
                     input logic [15:0] s2 = '0, input logic [15:0] s3 = '0,
                     input logic [15:0] s4 = '0);
    logic [15:0] s [5];
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3; s[4] = s4;
    OP   = op;
    Func = fn;
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_c%0d", tag, i + 1), ctrl, s[i]);
      tick();
    end
  endtask

  initial begin
    Reset = 1'b1;
    OP    = 6'b000000;
    Func  = 6'b100000;
    repeat (2) @(posedge CLK);
    #2;
    check("reset_held", ctrl, ERstFet);
    Reset = 1'b0;
    #1;
    check("post_reset_fetch", ctrl, EFetch);
    tick();
    check("post_reset_decode", ctrl, EDecode);
    tick();  // R-type add: EXECUTE
    tick();  // ALUWB
    tick();  // back to FETCH

    run("lw", 6'b100011, 6'b000000, 5, EFetch, EDecode, EMemAdr, EMemRd, EMemWb);
    run("sw", 6'b101011, 6'b000000, 4, EFetch, EDecode, EMemAdr, EMemWr);
    run("add", 6'b000000, 6'b100000, 4, EFetch, EDecode, e_exec(3'b010), EAluWb);
    run("sub", 6'b000000, 6'b100010, 4, EFetch, EDecode, e_exec(3'b110), EAluWb);
    run("and", 6'b000000, 6'b100100, 4, EFetch, EDecode, e_exec(3'b000), EAluWb);
    run("or", 6'b000000, 6'b100101, 4, EFetch, EDecode, e_exec(3'b001), EAluWb);
    run("slt", 6'b000000, 6'b101010, 4, EFetch, EDecode, e_exec(3'b111), EAluWb);
    run("rbad", 6'b000000, 6'b000000, 4, EFetch, EDecode, e_exec(3'b010), EAluWb);
    run("beq", 6'b000100, 6'b000000, 3, EFetch, EDecode, EBeqEx);
    run("j", 6'b000010, 6'b000000, 3, EFetch, EDecode, EJex);
    run("addi", 6'b001000, 6'b000000, 4, EFetch, EDecode, EMemAdr, EAddiWb);
    run("bad_op", 6'b111111, 6'b000000, 2, EFetch, EDecode);
    check("after_bad_op", ctrl, EFetch);

    // Reset arriving during MEMRD of a load abandons it.
    run("lw_abort", 6'b100011, 6'b000000, 3, EFetch, EDecode, EMemAdr);
    check("lw_abort_memrd", ctrl, EMemRd);
    Reset = 1'b1;
    #1;
    check("reset_mid_memrd", ctrl, ERstFet);
    tick();
    check("reset_mid_held", ctrl, ERstFet);
    Reset = 1'b0;
    #1;
    check("reset_mid_fetch", ctrl, EFetch);
    tick();
    check("reset_mid_decode", ctrl, EDecode);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
